// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin N:1 arbiter steering data through a MUX2 tree into a valid/ready output register.
// Optional burst lock per requester when RR_ARB_LOCK_EN is defined.
module mux2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);
    assign y = s ? b : a;
endmodule

module rr_mux_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic [N*W-1:0] data_in,
`ifdef RR_ARB_LOCK_EN
    input  logic [N-1:0]  lock,
`endif
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] sel,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, nxt;
    logic [SW-1:0] ptr, win, idx;
    logic hit, free, do_gnt;
    logic [W-1:0] node [2*N-1];
    assign out_valid = (state == FULL);
    assign free = ~out_valid | out_ready;
    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win = '0;
        hit = 1'b0;
        idx = '0;
        for (int o = N-1; o >= 0; o--) begin
            idx = ptr + SW'(o);
            if (req[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
`ifdef RR_ARB_LOCK_EN
        if (lock[sel] && req[sel]) begin
            win = sel;
            hit = 1'b1;
        end
`endif
    end
    assign do_gnt = rst_n & free & hit;
    assign gnt = do_gnt ? (N'(1) << win) : '0;
    always_comb begin
        nxt = do_gnt ? FULL : (free ? EMPTY : state);
    end
    // Heap-ordered tree: leaves at N-1.., node j feeds from 2j+1/2j+2, root uses the MSB.
    for (genvar i = 0; i < N; i++) begin : g_leaf
        assign node[N-1+i] = data_in[i*W +: W];
    end
    for (genvar i = 0; i < N-1; i++) begin : g_node
        localparam int D = $clog2(i+2) - 1;
        mux2 #(.W(W)) u_mux (.a(node[2*i+1]), .b(node[2*i+2]), .s(win[SW-1-D]), .y(node[i]));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ptr      <= '0;
            sel      <= '0;
            out_data <= '0;
        end else begin
            state <= nxt;
            if (do_gnt) begin
                ptr      <= win + SW'(1);
                sel      <= win;
                out_data <= node[0];
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed vectors with hand-computed expectations for rr_mux_arbiter (N=4, W=8).
module tb_rr_mux_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] data_in;
    logic [N-1:0] gnt;
    logic [1:0] sel;
    logic out_valid, out_ready = 1'b1;
    logic [W-1:0] out_data;
`ifdef RR_ARB_LOCK_EN
    logic [N-1:0] lock = '0;
`endif
    int n_vec = 0;
    int n_err = 0;

    rr_mux_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
`ifdef RR_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"}, 32'(out_data), 32'(d));
        check({tag, ".sel"}, 32'(sel), 32'(s));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_g [4];

    initial begin
        for (int i = 0; i < N; i++) data_in[i*W +: W] = 8'h10 + 8'(i);
        req = 4'b1111;
        #12;
        check_out("reset", 1'b0, 8'h00, 2'd0);
        check("reset.gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Full rotation with back-to-back beats.
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr%0d.gnt", i), 32'(gnt), 32'(4'b0001 << (i % 4)));
            tick();
            check_out($sformatf("rr%0d", i), 1'b1, 8'h10 + 8'(i % 4), 2'(i % 4));
        end
        req = 4'b0000;
        #1;
        check("idle.gnt", 32'(gnt), 32'h0);
        tick();
        check("drain.valid", 32'(out_valid), 32'h0);
        // Single request into a stalled consumer.
        req = 4'b0100;
        out_ready = 1'b0;
        #1;
        check("stall.gnt", 32'(gnt), 32'b0100);
        tick();
        check_out("stall.load", 1'b1, 8'h12, 2'd2);
        req = 4'b0000;
        data_in[2*W +: W] = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d.gnt", i), 32'(gnt), 32'h0);
            tick();
            check_out($sformatf("hold%0d", i), 1'b1, 8'h12, 2'd2);
        end
        data_in[2*W +: W] = 8'h12;
        out_ready = 1'b1;
        tick();
        check("release.valid", 32'(out_valid), 32'h0);
        // Stall with a pending request, then grant on the releasing edge.
        req = 4'b0100;
        out_ready = 1'b0;
        tick();
        check_out("pend.load", 1'b1, 8'h12, 2'd2);
        req = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("pend%0d.gnt", i), 32'(gnt), 32'h0);
            tick();
        end
        check_out("pend.held", 1'b1, 8'h12, 2'd2);
        out_ready = 1'b1;
        #1;
        check("pend.gnt", 32'(gnt), 32'b0001);
        tick();
        check_out("pend.b2b", 1'b1, 8'h10, 2'd0);
        req = 4'b0000;
        tick();
        check("pend.drain", 32'(out_valid), 32'h0);
        // Reset while a beat is held and ptr=3.
        req = 4'b0100;
        out_ready = 1'b0;
        tick();
        check_out("mid.load", 1'b1, 8'h12, 2'd2);
        req = 4'b1001;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("mid.rst", 1'b0, 8'h00, 2'd0);
        check("mid.rst.gnt", 32'(gnt), 32'h0);
        tick();
        check("mid.rst.hold", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid.first.gnt", 32'(gnt), 32'b0001);
        tick();
        check_out("mid.first", 1'b1, 8'h10, 2'd0);
        // Lock behaviour (or plain alternation without the lock port).
        req = 4'b0000;
        out_ready = 1'b1;
        do_reset();
        req = 4'b0011;
`ifdef RR_ARB_LOCK_EN
        lock = 4'b0001;
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        exp_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef RR_ARB_LOCK_EN
            if (i == 3) lock = 4'b0000;
            #1;
`endif
            check($sformatf("lk%0d.gnt", i), 32'(gnt), 32'(exp_g[i]));
            tick();
            check_out($sformatf("lk%0d", i), 1'b1, exp_g[i][0] ? 8'h10 : 8'h11, exp_g[i][0] ? 2'd0 : 2'd1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
